// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // FSM state encoding (2 bits)
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10
    } hz_state_e;

    // Architectural zero register; never a real producer
    localparam logic [4:0] REG_X0 = 5'd0;

    // Default MEM_WAIT timeout and the width that holds its full range
    localparam int TIMEOUT_CYC_DEF = 255;
    localparam int WAIT_W          = 16;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, stall/flush controls out.
// master = pipeline side that drives status, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       ex_valid_i;
    logic       ex_memread_i;
    logic [4:0] ex_rsd_i;
    logic       branch_taken_i;
    logic       mem_busy_i;
    logic       pc_write_o;
    logic       if_id_write_o;
    logic       if_id_flush_o;
    logic       id_ex_write_o;
    logic       id_ex_bubble_o;
    logic       timeout_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, ex_valid_i, ex_memread_i,
               ex_rsd_i, branch_taken_i, mem_busy_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o,
               id_ex_bubble_o, timeout_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, ex_valid_i, ex_memread_i,
               ex_rsd_i, branch_taken_i, mem_busy_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o,
               id_ex_bubble_o, timeout_o
    );
endinterface

// File: rtl/hazard_ctrl_stat_cnt.sv
// hazard_stat_cnt: wrap-around event counter with enable and sync clear.
module hazard_stat_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count enabled cycles; clear has priority over enable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, memory freeze and branch flush control
// for a 5-stage pipeline. Outputs are Mealy (state + current inputs).
// Optional statistics counters are built when HAZARD_CTRL_STATS_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hazard_ctrl_if.slave     bus
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] mem_wait_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    // Elaboration-time parameter sanity
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
        $error("hazard_ctrl: TIMEOUT_CYC out of range");
    end
    if (CNT_W < 1) begin : g_bad_cntw
        $error("hazard_ctrl: CNT_W must be >= 1");
    end

    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT_CYC);

    hz_state_e         r_state, w_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
    logic              r_timeout;

    logic w_lu, w_lu_take, w_busy_take;
    logic w_pc, w_ifid, w_idex, w_flush, w_bub;

    // Raw load-use match between the load in EX and the sources in ID
    assign w_lu = bus.id_valid_i & bus.ex_valid_i & bus.ex_memread_i &
                  (bus.ex_rsd_i != REG_X0) &
                  ((bus.ex_rsd_i == bus.id_rs1_i) | (bus.ex_rsd_i == bus.id_rs2_i));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_RUN;
        else       r_state <= w_nxt;
    end

    // Next state and Mealy outputs; priority is reset > mem_busy > LU > branch
    always_comb begin
        w_nxt       = ST_RUN;
        w_pc        = 1'b1;
        w_ifid      = 1'b1;
        w_idex      = 1'b1;
        w_flush     = 1'b0;
        w_bub       = 1'b0;
        w_lu_take   = 1'b0;
        w_busy_take = 1'b0;
        if (rst_i) begin
            w_pc    = 1'b0;
            w_ifid  = 1'b0;
            w_idex  = 1'b0;
            w_flush = 1'b1;
            w_bub   = 1'b1;
        end else if (bus.mem_busy_i) begin
            // Whole pipeline frozen, nothing inserted or cleared
            w_pc        = 1'b0;
            w_ifid      = 1'b0;
            w_idex      = 1'b0;
            w_busy_take = 1'b1;
            w_nxt       = ST_MEM_WAIT;
        end else begin
            case (r_state)
                // EX holds the bubble now, so LU is not re-evaluated
                ST_LU_STALL: w_flush = bus.branch_taken_i;
                // RUN, and MEM_WAIT releasing, both act as RUN this cycle
                default: begin
                    if (w_lu) begin
                        // Branch is dropped; it re-resolves after the stall
                        w_pc      = 1'b0;
                        w_ifid    = 1'b0;
                        w_bub     = 1'b1;
                        w_lu_take = 1'b1;
                        w_nxt     = ST_LU_STALL;
                    end else begin
                        w_flush = bus.branch_taken_i;
                    end
                end
            endcase
        end
    end

    // A wait cycle is any frozen cycle; the count saturates at the timeout
    assign w_wait_nxt = !w_busy_take      ? '0 :
                        (r_wait_cnt == TMO) ? r_wait_cnt : r_wait_cnt + 1'b1;

    // Consecutive wait-cycle counter, cleared once the freeze ends
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_wait_cnt <= '0;
        else       r_wait_cnt <= w_wait_nxt;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                 r_timeout <= 1'b0;
        else if (w_busy_take && (w_wait_nxt == TMO)) r_timeout <= 1'b1;
    end

    assign bus.pc_write_o     = w_pc;
    assign bus.if_id_write_o  = w_ifid;
    assign bus.id_ex_write_o  = w_idex;
    assign bus.if_id_flush_o  = w_flush;
    assign bus.id_ex_bubble_o = w_bub;
    assign bus.timeout_o      = r_timeout;

`ifdef HAZARD_CTRL_STATS_EN
    logic w_flush_take;

    // Flushes caused by a taken branch (reset's forced flush is not counted)
    assign w_flush_take = w_flush & ~rst_i;

    hazard_stat_cnt #(.W(CNT_W)) u_cnt_lu (
        .clk_i(clk_i), .rst_i(rst_i), .i_en(w_lu_take), .i_clr(1'b0), .o_cnt(lu_stall_cnt_o)
    );
    hazard_stat_cnt #(.W(CNT_W)) u_cnt_mw (
        .clk_i(clk_i), .rst_i(rst_i), .i_en(w_busy_take), .i_clr(1'b0), .o_cnt(mem_wait_cnt_o)
    );
    hazard_stat_cnt #(.W(CNT_W)) u_cnt_fl (
        .clk_i(clk_i), .rst_i(rst_i), .i_en(w_flush_take), .i_clr(1'b0), .o_cnt(flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random
// stimulus, each cycle compared against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int TMO   = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if bus();

`ifdef HAZARD_CTRL_STATS_EN
    logic [CNT_W-1:0] lu_cnt, mw_cnt, fl_cnt;
`endif

    hazard_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef HAZARD_CTRL_STATS_EN
        ,
        .lu_stall_cnt_o (lu_cnt),
        .mem_wait_cnt_o (mw_cnt),
        .flush_cnt_o    (fl_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: "did the previous cycle insert a load-use bubble",
    // length of the current run of frozen cycles, sticky timeout, event counts
    bit m_stalled;
    int m_busy_run;
    bit m_tmo;
    int m_lu, m_mw, m_fl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare at negedge, advance model and clock
    task automatic step(input string tag, input bit r, input bit idv, input int rs1, input int rs2,
                        input bit exv, input bit exm, input int rsd, input bit br, input bit busy);
        bit lu;
        bit [5:0] exp;
        bit [5:0] got;
        rst                = r;
        bus.id_valid_i     = idv;
        bus.id_rs1_i       = 5'(rs1);
        bus.id_rs2_i       = 5'(rs2);
        bus.ex_valid_i     = exv;
        bus.ex_memread_i   = exm;
        bus.ex_rsd_i       = 5'(rsd);
        bus.branch_taken_i = br;
        bus.mem_busy_i     = busy;
        @(negedge clk);
        lu = !r && !busy && !m_stalled && idv && exv && exm && rsd != 0 && (rsd == rs1 || rsd == rs2);
        // exp = {pc, ifid, flush, idex, bubble, timeout}
        if (r)         exp = 6'b001010;
        else if (busy) exp = {5'b00000, m_tmo};
        else if (lu)   exp = {5'b00011, m_tmo};
        else           exp = {2'b11, br, 2'b10, m_tmo};
        got = {bus.pc_write_o, bus.if_id_write_o, bus.if_id_flush_o,
               bus.id_ex_write_o, bus.id_ex_bubble_o, bus.timeout_o};
        chk(tag, 32'(got), 32'(exp));
`ifdef HAZARD_CTRL_STATS_EN
        chk({tag, "_lucnt"}, lu_cnt, m_lu);
        chk({tag, "_mwcnt"}, mw_cnt, m_mw);
        chk({tag, "_flcnt"}, fl_cnt, m_fl);
`endif
        if (r) begin
            m_stalled = 0; m_busy_run = 0; m_tmo = 0;
            m_lu = 0; m_mw = 0; m_fl = 0;
        end else begin
            m_stalled  = lu;
            m_busy_run = busy ? ((m_busy_run < TMO) ? m_busy_run + 1 : TMO) : 0;
            if (m_busy_run == TMO) m_tmo = 1;
            if (lu)              m_lu++;
            if (busy)            m_mw++;
            if (!busy && !lu && br) m_fl++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_stalled = 0; m_busy_run = 0; m_tmo = 0;
        m_lu = 0; m_mw = 0; m_fl = 0;
        #1;
        // Reset state
        step("reset0", 1, 1, 5, 5, 1, 1, 5, 1, 1);
        step("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("run_idle");

        // Load x5 in EX, ID reads x5: one stall cycle, then RUN
        step("lu_x5", 0, 1, 5, 7, 1, 1, 5, 0, 0);
        step("lu_after", 0, 1, 5, 7, 0, 0, 0, 0, 0);
        idle("lu_run");
`ifdef HAZARD_CTRL_STATS_EN
        chk("lu_cnt_one", lu_cnt, 1);
`endif

        // Load to x0 matching rs2=x0: no stall
        step("lu_x0", 0, 1, 3, 0, 1, 1, 0, 0, 0);

        // Freeze 3 cycles with LU and branch pending, then stall, then flush
        step("mw_lu_br0", 0, 1, 9, 2, 1, 1, 9, 1, 1);
        step("mw_lu_br1", 0, 1, 9, 2, 1, 1, 9, 1, 1);
        step("mw_lu_br2", 0, 1, 9, 2, 1, 1, 9, 1, 1);
        step("mw_rel_lu", 0, 1, 9, 2, 1, 1, 9, 1, 0);
        step("mw_rel_br", 0, 1, 9, 2, 0, 0, 0, 1, 0);
        idle("mw_rel_run");

        // Timeout: busy 6 cycles, flag rises after the 4th and stays
        rst = 1; #1;
        step("tmo_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("tmo_busy", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle("tmo_rel");
        idle("tmo_run");
        chk("tmo_sticky", 32'(bus.timeout_o), 32'd1);

        // Reset pulsed mid-freeze aborts at once; timeout cleared
        step("rmw_busy0", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("rmw_busy1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("rmw_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("rmw_run", 0, 1, 4, 4, 0, 0, 0, 1, 0);
        chk("rmw_tmo_clr", 32'(bus.timeout_o), 32'd0);

        // Branch during the stall cycle flushes; LU inputs still present
        step("lsb_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lsb_lu", 0, 1, 6, 1, 1, 1, 6, 1, 0);
        step("lsb_br", 0, 1, 6, 1, 1, 1, 6, 1, 0);
`ifdef HAZARD_CTRL_STATS_EN
        chk("lsb_fl_cnt", fl_cnt, 1);
`endif

        // Reset pulsed mid-stall aborts the stall
        step("rls_lu", 0, 1, 6, 1, 1, 1, 6, 0, 0);
        step("rls_rst", 1, 1, 6, 1, 1, 1, 6, 0, 0);
        step("rls_run", 0, 1, 6, 1, 1, 1, 6, 0, 0);

        // Random traffic; small register range to make matches frequent
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 99) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max consecutive MEM_WAIT cycles before a timeout error is raised (range 1..65535).
REQ-002 Parameter CNT_W, default 32, width of the statistics counters.
REQ-003 clk_i  in  1  single clock; all state updates on posedge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 id_valid_i  in  1  ID stage holds a valid instruction.
REQ-006 id_rs1_i, id_rs2_i  in  5 each  source registers of the instruction in ID.
REQ-007 ex_valid_i  in  1  ID/EX buffer holds a valid instruction.
REQ-008 ex_memread_i  in  1  instruction in EX is a load.
REQ-009 ex_rsd_i  in  5  destination register of the instruction in EX.
REQ-010 branch_taken_i  in  1  branch in ID resolved taken this cycle.
REQ-011 mem_busy_i  in  1  data memory not ready; the whole pipeline must freeze.
REQ-012 pc_write_o  out  1  PC update enable.
REQ-013 if_id_write_o  out  1  IF/ID buffer load enable.
REQ-014 if_id_flush_o  out  1  clears IF/ID valid.
REQ-015 id_ex_write_o  out  1  ID/EX buffer load enable.
REQ-016 id_ex_bubble_o  out  1  forces valid_i=0 and branch_i=0 into the ID/EX buffer.
REQ-017 timeout_o  out  1  sticky MEM_WAIT timeout error.

Function
REQ-018 Load-use hazard (LU) SHALL be: id_valid_i & ex_valid_i & ex_memread_i & (ex_rsd_i != 0) & (ex_rsd_i == id_rs1_i | ex_rsd_i == id_rs2_i).
REQ-019 FSM states SHALL be RUN, LU_STALL and MEM_WAIT, with 2-bit encoding from the package.
REQ-020 In RUN with no event: pc_write_o=1, if_id_write_o=1, id_ex_write_o=1, if_id_flush_o=0, id_ex_bubble_o=0.
REQ-021 Event priority SHALL be: mem_busy_i > LU > branch_taken_i.
REQ-022 mem_busy_i=1 in any state: all write enables 0, flush and bubble 0, next state MEM_WAIT.
REQ-023 MEM_WAIT: outputs as REQ-022 while mem_busy_i=1; on mem_busy_i=0 return to RUN and evaluate LU/branch in that same cycle as in RUN.
REQ-024 LU in RUN (mem_busy_i=0): pc_write_o=0, if_id_write_o=0, id_ex_write_o=1, id_ex_bubble_o=1; next state LU_STALL.
REQ-025 LU_STALL: exactly one cycle; LU is not re-detected (EX now holds the bubble); outputs as RUN; next state RUN.
REQ-026 branch_taken_i is ignored in the same cycle as LU; the branch re-resolves after the stall.
REQ-027 branch_taken_i in RUN or LU_STALL with no higher-priority event: if_id_flush_o=1 for that single cycle, other outputs as RUN.
REQ-028 A wait counter SHALL increment each MEM_WAIT cycle, saturate at TIMEOUT_CYC, and clear on leaving MEM_WAIT.
REQ-029 timeout_o SHALL set when the counter reaches TIMEOUT_CYC and clear only on reset.
REQ-030 Outputs SHALL be Mealy: a function of the current state and inputs, with no added latency.

Reset
REQ-031 While rst_i=1: state RUN, wait counter 0, timeout_o=0, all write enables 0, if_id_flush_o=1, id_ex_bubble_o=1.
REQ-032 Assertion of rst_i mid-MEM_WAIT or mid-LU_STALL SHALL abort immediately; the first cycle after deassertion behaves as RUN.

Configuration
REQ-033 Macro HAZARD_CTRL_STATS_EN, when defined, adds outputs lu_stall_cnt_o, mem_wait_cnt_o and flush_cnt_o (CNT_W bits, wrap-around, reset 0); these count cycles per REQ-024, REQ-022 and REQ-027 respectively.
REQ-034 When HAZARD_CTRL_STATS_EN is undefined, those ports and counters SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-035 Package hazard_pkg SHALL hold the state typedef/encodings, the x0 register constant and the default TIMEOUT_CYC.
REQ-036 One sub-module, hazard_stat_cnt (enable/clear counter), SHALL be instantiated three times under HAZARD_CTRL_STATS_EN.

Verification
REQ-037 Load x5 in EX, ID reads rs1=5 -> one cycle pc_write_o=0, id_ex_bubble_o=1, then RUN; lu_stall_cnt_o=1.
REQ-038 Load with ex_rsd_i=0 matching id_rs2_i=0 -> no stall.
REQ-039 mem_busy_i high 3 cycles together with LU and branch -> 3 frozen cycles, then LU stall, then flush when the branch re-resolves taken.
REQ-040 TIMEOUT_CYC=4, mem_busy_i held 6 cycles -> timeout_o rises after the 4th MEM_WAIT cycle and stays 1 after mem_busy_i falls.
REQ-041 rst_i pulsed during MEM_WAIT -> outputs per REQ-031 immediately; next cycle RUN; timeout_o=0.
REQ-042 branch_taken_i in LU_STALL -> if_id_flush_o=1 that cycle, flush_cnt_o=1.
